// File: rtl/capture_kf_pkg.sv
// Shared types and command-word bit positions for the capture1 base_kf table loader.
package capture_kf_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_LOAD  = 2'd1,
        WAIT_CLEAR = 2'd2,
        CLEAR      = 2'd3
    } kf_state_e;

    localparam int unsigned LOAD_BIT   = 31;
    localparam int unsigned CLEAR_BIT  = 30;
    localparam int unsigned ERRCLR_BIT = 29;

endpackage

// File: rtl/kf_table_ram.sv
// Simple dual-port coefficient RAM: one write port, one registered read port, read-first.
module kf_table_ram #(
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Same-address read returns the pre-write contents.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_o <= mem_q[raddr_i];
    end

endmodule

// File: rtl/capture_kf_table_loader.sv
// Commits software base_kf writes into the per-channel table on frame boundaries,
// runs full-table clear sweeps, and streams the coefficient for each TDM channel.
module capture_kf_table_loader
    import capture_kf_pkg::*;
#(
    parameter int unsigned N_CHAN = 256,
    parameter int unsigned CHAN_W = 8,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              user_clk,
    input  logic              user_rst,
    input  logic [DATA_W-1:0] base_kf_in,
    input  logic [31:0]       load_ctrl_in,
    input  logic              sync_in,
    input  logic [CHAN_W-1:0] ch_in,
    output logic [DATA_W-1:0] kf_out,
    output logic [CHAN_W-1:0] ch_out,
    output logic              sync_out,
    output logic              busy,
    output logic              load_err,
    output logic [CNT_W-1:0]  load_count
);

    kf_state_e         state_q, state_d;
    logic              load_prev_q, clr_prev_q, errclr_prev_q, armed_q;
    logic              load_edge_c, clr_edge_c, errclr_edge_c;
    logic [DATA_W-1:0] pend_data_q, pend_data_d;
    logic [CHAN_W-1:0] pend_chan_q, pend_chan_d;
    logic [CNT_W-1:0]  count_d;
    logic              last_q, last_d;
    logic              err_d, err_set_c, sweep_c;
    logic              ram_we_c;
    logic [CHAN_W-1:0] ram_waddr_c;
    logic [DATA_W-1:0] ram_wdata_c, ram_rdata;
    logic [CHAN_W-1:0] ch_s1_q;
    logic              sync_s1_q, zero_s1_q;
    logic              unused_ctrl_c;

    assign unused_ctrl_c = ^load_ctrl_in[28:CHAN_W];

    // armed_q masks the first post-reset cycle so a level held through reset never fires.
    assign load_edge_c   = armed_q & load_ctrl_in[LOAD_BIT]   & ~load_prev_q;
    assign clr_edge_c    = armed_q & load_ctrl_in[CLEAR_BIT]  & ~clr_prev_q;
    assign errclr_edge_c = armed_q & load_ctrl_in[ERRCLR_BIT] & ~errclr_prev_q;

    always_comb begin
        state_d     = state_q;
        pend_data_d = pend_data_q;
        pend_chan_d = pend_chan_q;
        count_d     = load_count;
        last_d      = last_q;
        err_set_c   = 1'b0;
        sweep_c     = 1'b0;
        ram_we_c    = 1'b0;
        ram_waddr_c = ch_in;
        ram_wdata_c = '0;
        case (state_q)
            IDLE: begin
                if (clr_edge_c) begin
                    state_d   = WAIT_CLEAR;
                    err_set_c = load_edge_c;
                end else if (load_edge_c) begin
                    pend_data_d = base_kf_in;
                    pend_chan_d = load_ctrl_in[CHAN_W-1:0];
                    state_d     = WAIT_LOAD;
                end
            end
            WAIT_LOAD: begin
                err_set_c = load_edge_c | clr_edge_c;
                if (sync_in) begin
                    ram_we_c    = 1'b1;
                    ram_waddr_c = pend_chan_q;
                    ram_wdata_c = pend_data_q;
                    count_d     = load_count + CNT_W'(1);
                    state_d     = IDLE;
                end
            end
            WAIT_CLEAR: begin
                err_set_c = load_edge_c | clr_edge_c;
                if (sync_in) begin
                    sweep_c = 1'b1;
                    last_d  = 1'b0;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                // One extra cycle after the channel N_CHAN-1 write keeps busy through it.
                err_set_c = load_edge_c | clr_edge_c;
                if (last_q) begin
                    state_d = IDLE;
                end else begin
                    sweep_c = 1'b1;
                    last_d  = (ch_in == CHAN_W'(N_CHAN - 1));
                end
            end
            default: state_d = IDLE;
        endcase
        if (sweep_c) begin
            ram_we_c = 1'b1;
        end
        if (user_rst) begin
            ram_we_c = 1'b0;
        end
        err_d = err_set_c | (load_err & ~errclr_edge_c);
    end

    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            state_q       <= IDLE;
            load_prev_q   <= 1'b0;
            clr_prev_q    <= 1'b0;
            errclr_prev_q <= 1'b0;
            armed_q       <= 1'b0;
            pend_data_q   <= '0;
            pend_chan_q   <= '0;
            last_q        <= 1'b0;
            busy          <= 1'b0;
            load_err      <= 1'b0;
            load_count    <= '0;
            ch_s1_q       <= '0;
            sync_s1_q     <= 1'b0;
            zero_s1_q     <= 1'b0;
            kf_out        <= '0;
            ch_out        <= '0;
            sync_out      <= 1'b0;
        end else begin
            state_q       <= state_d;
            load_prev_q   <= load_ctrl_in[LOAD_BIT];
            clr_prev_q    <= load_ctrl_in[CLEAR_BIT];
            errclr_prev_q <= load_ctrl_in[ERRCLR_BIT];
            armed_q       <= 1'b1;
            pend_data_q   <= pend_data_d;
            pend_chan_q   <= pend_chan_d;
            last_q        <= last_d;
            busy          <= (state_d != IDLE);
            load_err      <= err_d;
            load_count    <= count_d;
            ch_s1_q       <= ch_in;
            sync_s1_q     <= sync_in;
            zero_s1_q     <= sweep_c;
            kf_out        <= zero_s1_q ? '0 : ram_rdata;
            ch_out        <= ch_s1_q;
            sync_out      <= sync_s1_q;
        end
    end

    kf_table_ram #(
        .DEPTH (N_CHAN),
        .ADDR_W(CHAN_W),
        .DATA_W(DATA_W)
    ) u_table (
        .clk_i  (user_clk),
        .we_i   (ram_we_c),
        .waddr_i(ram_waddr_c),
        .wdata_i(ram_wdata_c),
        .raddr_i(ch_in),
        .rdata_o(ram_rdata)
    );

endmodule

// File: tb/tb_capture_kf_table_loader.sv
// Directed bench for capture_kf_table_loader: command vectors, table read-back, corner sequences.
module tb_capture_kf_table_loader;

    localparam int unsigned N_CHAN = 256;
    localparam int unsigned CHAN_W = 8;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 4;

    logic              user_clk = 1'b0;
    logic              user_rst;
    logic [DATA_W-1:0] base_kf_in;
    logic [31:0]       load_ctrl_in;
    logic              sync_in;
    logic [CHAN_W-1:0] ch_in;
    logic [DATA_W-1:0] kf_out;
    logic [CHAN_W-1:0] ch_out;
    logic              sync_out;
    logic              busy;
    logic              load_err;
    logic [CNT_W-1:0]  load_count;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0]      ctrl;
        logic [31:0]      data;
        logic [7:0]       at_ch;
        int               exp_busy;
        logic             exp_err;
        logic [CNT_W-1:0] exp_cnt;
    } cmd_vec_t;

    typedef struct {
        logic [7:0]  chan;
        logic [31:0] exp_kf;
    } rd_vec_t;

    cmd_vec_t cv [6];
    rd_vec_t  rv1 [6];
    rd_vec_t  rv2 [4];
    rd_vec_t  rv3 [7];

    capture_kf_table_loader #(
        .N_CHAN(N_CHAN), .CHAN_W(CHAN_W), .DATA_W(DATA_W), .CNT_W(CNT_W)
    ) dut (
        .user_clk    (user_clk),
        .user_rst    (user_rst),
        .base_kf_in  (base_kf_in),
        .load_ctrl_in(load_ctrl_in),
        .sync_in     (sync_in),
        .ch_in       (ch_in),
        .kf_out      (kf_out),
        .ch_out      (ch_out),
        .sync_out    (sync_out),
        .busy        (busy),
        .load_err    (load_err),
        .load_count  (load_count)
    );

    always #5 user_clk = ~user_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Advance one clock; the channel stream moves on right after the edge.
    task automatic tick();
        @(posedge user_clk);
        #1;
        ch_in   = ch_in + 8'd1;
        sync_in = (ch_in == 8'd0);
    endtask

    task automatic wait_ch(input logic [7:0] c);
        int g;
        g = 0;
        while (ch_in != c && g < 600) begin
            tick();
            g++;
        end
    endtask

    task automatic issue(input logic [31:0] ctrl, input logic [31:0] data);
        load_ctrl_in = ctrl;
        base_kf_in   = data;
        tick();
        load_ctrl_in = 32'h0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 2000) begin
            n++;
            tick();
        end
    endtask

    task automatic read_check(input string name, input logic [7:0] c, input logic [31:0] exp);
        int g;
        g = 0;
        tick();
        while (ch_out != c && g < 600) begin
            tick();
            g++;
        end
        check({name, "_ch"}, 32'(ch_out), 32'(c));
        check({name, "_sync"}, 32'(sync_out), 32'(c == 8'd0));
        check({name, "_kf"}, kf_out, exp);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic seen;

        cv[0] = '{32'h4000_0000, 32'h0,         8'd10,  502, 1'b0, 4'd0};
        cv[1] = '{32'h8000_0005, 32'hDEAD_BEEF, 8'd100, 156, 1'b0, 4'd1};
        cv[2] = '{32'h8000_0000, 32'h0000_0011, 8'd0,   256, 1'b0, 4'd2};
        cv[3] = '{32'h8000_0007, 32'h0000_0077, 8'd255, 1,   1'b0, 4'd3};
        cv[4] = '{32'h8000_00FF, 32'h0000_FF55, 8'd128, 128, 1'b0, 4'd4};
        cv[5] = '{32'h2000_0000, 32'h0,         8'd3,   0,   1'b0, 4'd4};

        rv1[0] = '{8'd0,   32'h0000_0011};
        rv1[1] = '{8'd5,   32'hDEAD_BEEF};
        rv1[2] = '{8'd7,   32'h0000_0077};
        rv1[3] = '{8'd255, 32'h0000_FF55};
        rv1[4] = '{8'd6,   32'h0};
        rv1[5] = '{8'd128, 32'h0};

        rv2[0] = '{8'd1,  32'h1111_1111};
        rv2[1] = '{8'd9,  32'h0};
        rv2[2] = '{8'd10, 32'h0};
        rv2[3] = '{8'd12, 32'h0};

        rv3[0] = '{8'd0,   32'h0};
        rv3[1] = '{8'd99,  32'h0};
        rv3[2] = '{8'd100, 32'h0000_0100};
        rv3[3] = '{8'd150, 32'h0000_0150};
        rv3[4] = '{8'd200, 32'h0000_0200};
        rv3[5] = '{8'd98,  32'h0};
        rv3[6] = '{8'd101, 32'h0};

        // Reset with the load bit already high: releasing reset must not fire a load.
        user_rst     = 1'b1;
        load_ctrl_in = 32'h8000_0005;
        base_kf_in   = 32'h1234_5678;
        ch_in        = 8'd0;
        sync_in      = 1'b1;
        repeat (4) tick();
        check("rst_kf", kf_out, 32'h0);
        check("rst_ch", 32'(ch_out), 32'h0);
        check("rst_sync", 32'(sync_out), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        user_rst = 1'b0;
        repeat (300) tick();
        check("held_busy", 32'(busy), 32'h0);
        check("held_cnt", 32'(load_count), 32'h0);
        check("held_err", 32'(load_err), 32'h0);
        check("pipe_ch", 32'(ch_out), 32'(8'(ch_in - 8'd2)));
        load_ctrl_in = 32'h0;
        tick();

        // Command vectors: busy length, error flag, committed-load count.
        for (int i = 0; i < 6; i++) begin
            wait_ch(cv[i].at_ch);
            issue(cv[i].ctrl, cv[i].data);
            wait_idle(n);
            check($sformatf("cmd%0d_busy", i), 32'(n), 32'(cv[i].exp_busy));
            check($sformatf("cmd%0d_err", i), 32'(load_err), 32'(cv[i].exp_err));
            check($sformatf("cmd%0d_cnt", i), 32'(load_count), 32'(cv[i].exp_cnt));
        end
        for (int i = 0; i < 6; i++) begin
            read_check($sformatf("rd1_%0d", i), rv1[i].chan, rv1[i].exp_kf);
        end

        // Clear-all: the whole sweep frame outputs zero even where the RAM still reads old data.
        wait_ch(8'd50);
        issue(32'h4000_0000, 32'h0);
        n    = 0;
        seen = 1'b0;
        while (busy && n < 2000) begin
            if (sync_out && !seen) begin
                seen = 1'b1;
                check("clr_ch0_forced", kf_out, 32'h0);
            end
            n++;
            tick();
        end
        check("clr_sync_seen", 32'(seen), 32'h1);
        check("clr_busy", 32'(n), 32'd462);
        check("clr_last_ch", 32'(ch_out), 32'd255);
        check("clr_ch255_forced", kf_out, 32'h0);
        for (int i = 0; i < 6; i++) begin
            read_check($sformatf("rdclr_%0d", i), rv1[i].chan, 32'h0);
        end

        // Load edge while a load is pending: ignored, error raised.
        wait_ch(8'd20);
        issue(32'h8000_0009, 32'hA5A5_0009);
        check("coll_busy", 32'(busy), 32'h1);
        wait_ch(8'd40);
        issue(32'h8000_000A, 32'hB0B0_000A);
        check("coll_err", 32'(load_err), 32'h1);
        wait_idle(n);
        check("coll_cnt", 32'(load_count), 32'd5);
        issue(32'h2000_0000, 32'h0);
        check("errclr", 32'(load_err), 32'h0);

        // Simultaneous load+clear from IDLE: clear runs, load dropped, error raised.
        wait_ch(8'd30);
        issue(32'hC000_000C, 32'hC0C0_000C);
        check("simul_err", 32'(load_err), 32'h1);
        wait_idle(n);
        check("simul_busy", 32'(n), 32'd482);
        check("simul_cnt", 32'(load_count), 32'd5);
        issue(32'h2000_0000, 32'h0);
        check("errclr2", 32'(load_err), 32'h0);

        // Error-clear edge coinciding with a new error: set wins.
        wait_ch(8'd60);
        issue(32'h8000_0001, 32'h1111_1111);
        tick();
        issue(32'hA000_0000, 32'h0000_0BAD);
        check("errclr_set_wins", 32'(load_err), 32'h1);
        wait_idle(n);
        check("swin_cnt", 32'(load_count), 32'd6);
        issue(32'h2000_0000, 32'h0);
        for (int i = 0; i < 4; i++) begin
            read_check($sformatf("rd2_%0d", i), rv2[i].chan, rv2[i].exp_kf);
        end

        // Commit to channel 0 coincides with its read: old value first, new value next frame.
        wait_ch(8'd128);
        issue(32'h8000_0000, 32'h5A5A_5A5A);
        wait_idle(n);
        tick();
        check("rw_ch", 32'(ch_out), 32'h0);
        check("rw_sync", 32'(sync_out), 32'h1);
        check("rw_old", kf_out, 32'h0);
        check("rw_cnt", 32'(load_count), 32'd7);
        read_check("rw_new", 8'd0, 32'h5A5A_5A5A);

        // Reset during the sweep after 100 writes: channels 100+ keep their values.
        wait_ch(8'd255); issue(32'h8000_0063, 32'h0000_0099); wait_idle(n);
        wait_ch(8'd255); issue(32'h8000_0064, 32'h0000_0100); wait_idle(n);
        wait_ch(8'd255); issue(32'h8000_0096, 32'h0000_0150); wait_idle(n);
        wait_ch(8'd255); issue(32'h8000_00C8, 32'h0000_0200); wait_idle(n);
        check("pre_rst_cnt", 32'(load_count), 32'd11);
        wait_ch(8'd200);
        issue(32'h4000_0000, 32'h0);
        wait_ch(8'd100);
        user_rst = 1'b1;
        tick();
        user_rst = 1'b0;
        check("mid_rst_busy", 32'(busy), 32'h0);
        check("mid_rst_cnt", 32'(load_count), 32'h0);
        check("mid_rst_kf", kf_out, 32'h0);
        check("mid_rst_ch", 32'(ch_out), 32'h0);
        repeat (300) tick();
        check("post_rst_busy", 32'(busy), 32'h0);
        for (int i = 0; i < 7; i++) begin
            read_check($sformatf("rd3_%0d", i), rv3[i].chan, rv3[i].exp_kf);
        end

        // load_count wrap; loading just before sync gives a one-cycle busy.
        for (int i = 1; i <= 16; i++) begin
            wait_ch(8'd255);
            issue(32'h8000_00C8, 32'(i));
            wait_idle(n);
            if (i == 1) check("wrap_busy1", 32'(n), 32'd1);
            if (i == 15) check("wrap_cnt15", 32'(load_count), 32'd15);
            if (i == 16) check("wrap_cnt0", 32'(load_count), 32'd0);
        end
        read_check("wrap_ch200", 8'd200, 32'd16);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
